// File: rtl/bus_ad_rtc.sv
// rtl/bus_ad_rtc.sv - RTC multiplexed address/data bus driver, one transaction per 32-cycle frame
module bus_ad_rtc #(
    parameter int TIMEOUT = 48
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       enable_cont_32,
    input  logic       habilitar,
    input  logic       LE,
    input  logic       A_D,
    input  logic       WR,
    input  logic       RD,
    input  logic [7:0] direccion,
    input  logic [7:0] dato_escritura,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic [7:0] dato_lectura,
    output logic       lectura_valida,
    output logic       listo,
    output logic       error,
    output logic       ocupado
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_t;

    // The watchdog reads 0 in T1, so this value makes error register in T(TIMEOUT).
    localparam logic [5:0] WD_LAST = 6'(TIMEOUT - 2);

    state_t     state_q, state_d;
    logic       a_d_q, wr_q, rd_q;
    logic [7:0] ad_in_q;
    logic [7:0] dir_l_q, dir_l_d;
    logic [7:0] dat_l_q, dat_l_d;
    logic       le_l_q, le_l_d;
    logic [5:0] wd_q, wd_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       ad_oe_q, ad_oe_d;
    logic [7:0] dato_lectura_q, dato_lectura_d;
    logic       lectura_valida_q, lectura_valida_d;
    logic       listo_q, listo_d;
    logic       error_q, error_d;
    logic       ocupado_q, ocupado_d;

    logic latch, a_d_rise, wr_rise, rd_rise, wd_expired;

    assign latch      = enable_cont_32 & habilitar;
    assign a_d_rise   = ~a_d_q & A_D;
    assign wr_rise    = ~wr_q & WR;
    assign rd_rise    = ~rd_q & RD;
    assign wd_expired = (wd_q == WD_LAST);

    always_comb begin
        state_d          = state_q;
        dir_l_d          = dir_l_q;
        dat_l_d          = dat_l_q;
        le_l_d           = le_l_q;
        wd_d             = wd_q;
        ad_out_d         = ad_out_q;
        ad_oe_d          = ad_oe_q;
        dato_lectura_d   = dato_lectura_q;
        lectura_valida_d = 1'b0;
        listo_d          = 1'b0;
        error_d          = 1'b0;

        if (latch) begin
            // A new frame request preempts whatever is in flight.
            error_d  = (state_q != IDLE);
            dir_l_d  = direccion;
            dat_l_d  = dato_escritura;
            le_l_d   = LE;
            wd_d     = 6'd0;
            state_d  = ADDR;
            ad_out_d = direccion;
            ad_oe_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    ad_oe_d = 1'b0;
                end
                ADDR: begin
                    wd_d = wd_q + 6'd1;
                    if (a_d_rise) begin
                        if (le_l_q) begin
                            state_d = RDATA;
                            ad_oe_d = 1'b0;
                        end else begin
                            state_d  = WDATA;
                            ad_out_d = dat_l_q;
                            ad_oe_d  = 1'b1;
                        end
                    end else if (wd_expired) begin
                        error_d = 1'b1;
                        ad_oe_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                WDATA: begin
                    wd_d = wd_q + 6'd1;
                    if (wr_rise) begin
                        listo_d = 1'b1;
                        ad_oe_d = 1'b0;
                        state_d = IDLE;
                    end else if (wd_expired) begin
                        error_d = 1'b1;
                        ad_oe_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                RDATA: begin
                    wd_d = wd_q + 6'd1;
                    if (rd_rise) begin
                        dato_lectura_d   = ad_in_q;
                        lectura_valida_d = 1'b1;
                        listo_d          = 1'b1;
                        state_d          = IDLE;
                    end else if (wd_expired) begin
                        error_d = 1'b1;
                        ad_oe_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    ad_oe_d = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end

        ocupado_d = (state_d != IDLE);
    end

    // Strobe copies reset high so the first sample after reset cannot look like a rising edge.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            state_q          <= IDLE;
            a_d_q            <= 1'b1;
            wr_q             <= 1'b1;
            rd_q             <= 1'b1;
            ad_in_q          <= 8'h00;
            dir_l_q          <= 8'h00;
            dat_l_q          <= 8'h00;
            le_l_q           <= 1'b0;
            wd_q             <= 6'd0;
            ad_out_q         <= 8'h00;
            ad_oe_q          <= 1'b0;
            dato_lectura_q   <= 8'h00;
            lectura_valida_q <= 1'b0;
            listo_q          <= 1'b0;
            error_q          <= 1'b0;
            ocupado_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            a_d_q            <= A_D;
            wr_q             <= WR;
            rd_q             <= RD;
            ad_in_q          <= ad_in;
            dir_l_q          <= dir_l_d;
            dat_l_q          <= dat_l_d;
            le_l_q           <= le_l_d;
            wd_q             <= wd_d;
            ad_out_q         <= ad_out_d;
            ad_oe_q          <= ad_oe_d;
            dato_lectura_q   <= dato_lectura_d;
            lectura_valida_q <= lectura_valida_d;
            listo_q          <= listo_d;
            error_q          <= error_d;
            ocupado_q        <= ocupado_d;
        end
    end

    assign ad_out         = ad_out_q;
    assign ad_oe          = ad_oe_q;
    assign dato_lectura   = dato_lectura_q;
    assign lectura_valida = lectura_valida_q;
    assign listo          = listo_q;
    assign error          = error_q;
    assign ocupado        = ocupado_q;

endmodule

// File: tb/tb_bus_ad_rtc.sv
// tb/tb_bus_ad_rtc.sv - scoreboard bench for bus_ad_rtc with a frame-level reference model
module tb_bus_ad_rtc;

    logic       reloj = 1'b0;
    logic       resetM = 1'b1;
    logic       enable_cont_32 = 1'b0;
    logic       habilitar = 1'b0;
    logic       LE = 1'b0;
    logic       A_D = 1'b1;
    logic       WR = 1'b1;
    logic       RD = 1'b1;
    logic [7:0] direccion = 8'h00;
    logic [7:0] dato_escritura = 8'h00;
    logic [7:0] ad_in = 8'h00;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] dato_lectura;
    logic       lectura_valida;
    logic       listo;
    logic       error;
    logic       ocupado;

    bus_ad_rtc #(.TIMEOUT(48)) dut (
        .reloj(reloj), .resetM(resetM), .enable_cont_32(enable_cont_32),
        .habilitar(habilitar), .LE(LE), .A_D(A_D), .WR(WR), .RD(RD),
        .direccion(direccion), .dato_escritura(dato_escritura), .ad_in(ad_in),
        .ad_out(ad_out), .ad_oe(ad_oe), .dato_lectura(dato_lectura),
        .lectura_valida(lectura_valida), .listo(listo), .error(error), .ocupado(ocupado)
    );

    always #5 reloj = ~reloj;

    typedef struct {
        int         cyc;
        bit         oe;
        bit         chk_out;
        logic [7:0] out;
        bit         ocup;
    } bus_t;

    typedef struct {
        int         cyc;
        bit         listo;
        bit         err;
        bit         lv;
        logic [7:0] dato;
    } evt_t;

    bus_t       bus_q[$];
    evt_t       evt_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [7:0] model_dato = 8'h00;

    always @(posedge reloj) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_bus(input int c, input bit oe, input bit chk_out, input logic [7:0] out, input bit ocup);
        bus_t b;
        b.cyc = c; b.oe = oe; b.chk_out = chk_out; b.out = out; b.ocup = ocup;
        bus_q.push_back(b);
    endtask

    task automatic push_evt(input int c, input bit l, input bit e, input bit lv, input logic [7:0] d);
        evt_t x;
        x.cyc = c; x.listo = l; x.err = e; x.lv = lv; x.dato = d;
        evt_q.push_back(x);
    endtask

    // mode 0: nominal strobes; mode 1: A_D held low long enough to trip the watchdog.
    // cut truncates the frame (the next frame or a reset takes over at that position).
    task automatic run_frame(input bit hab, input bit le, input int mode, input int cut,
                             input int dir, input int dat, input int rdv);
        int         c0 = 0;
        int         len;
        logic [7:0] d_l = 8'h00;
        logic [7:0] w_l = 8'h00;
        len = (mode == 1) ? 52 : 32;
        if (cut < len) len = cut;
        for (int p = 0; p < len; p++) begin
            @(posedge reloj);
            #1;
            if (p == 0) begin
                c0  = cyc;
                d_l = (dir < 0) ? 8'($urandom) : 8'(dir);
                w_l = (dat < 0) ? 8'($urandom) : 8'(dat);
            end
            enable_cont_32 = (p == 0);
            habilitar      = (p == 0) ? hab : 1'($urandom);
            LE             = (p == 0) ? le : 1'($urandom);
            direccion      = (p == 0) ? d_l : 8'($urandom);
            dato_escritura = (p == 0) ? w_l : 8'($urandom);
            A_D = !(hab && ((mode == 1) ? (p >= 2 && p <= 49) : (p >= 2 && p <= 11)));
            WR  = !(hab && mode == 0 && !le && p >= 21 && p <= 27);
            RD  = !(hab && mode == 0 && le && p >= 21 && p <= 27);
            ad_in = (rdv >= 0 && p >= 21 && p <= 27) ? 8'(rdv) : 8'($urandom);

            if (p >= 1) begin
                if (!hab) push_bus(c0 + p, 0, 0, 8'h00, 0);
                else if (mode == 1) begin
                    if (p <= 47) push_bus(c0 + p, 1, 1, d_l, 1);
                    else         push_bus(c0 + p, 0, 1, d_l, 0);
                end else if (!le) begin
                    if (p <= 12)      push_bus(c0 + p, 1, 1, d_l, 1);
                    else if (p <= 28) push_bus(c0 + p, 1, 1, w_l, 1);
                    else              push_bus(c0 + p, 0, 1, w_l, 0);
                end else begin
                    if (p <= 12)      push_bus(c0 + p, 1, 1, d_l, 1);
                    else if (p <= 28) push_bus(c0 + p, 0, 0, 8'h00, 1);
                    else              push_bus(c0 + p, 0, 0, 8'h00, 0);
                end
            end
            if (hab && p == 1) begin
                if (mode == 1)  push_evt(c0 + 48, 0, 1, 0, model_dato);
                else if (!le)   push_evt(c0 + 29, 1, 0, 0, model_dato);
            end
            if (hab && mode == 0 && le && p == 27) begin
                model_dato = ad_in;
                push_evt(c0 + 29, 1, 0, 1, model_dato);
            end
        end
    endtask

    always @(negedge reloj) begin
        bus_t b;
        evt_t e;
        if (!resetM) begin
            if (bus_q.size() > 0 && bus_q[0].cyc <= cyc) begin
                b = bus_q.pop_front();
                chk("bus_cycle", 32'(cyc), 32'(b.cyc));
                chk("ad_oe", 32'(ad_oe), 32'(b.oe));
                if (b.chk_out) chk("ad_out", 32'(ad_out), 32'(b.out));
                chk("ocupado", 32'(ocupado), 32'(b.ocup));
            end
            if (listo || error || lectura_valida) begin
                if (evt_q.size() == 0) begin
                    chk("unexpected_pulse", {29'd0, listo, error, lectura_valida}, 32'd0);
                end else begin
                    e = evt_q.pop_front();
                    chk("evt_cycle", 32'(cyc), 32'(e.cyc));
                    chk("listo", 32'(listo), 32'(e.listo));
                    chk("error", 32'(error), 32'(e.err));
                    chk("lectura_valida", 32'(lectura_valida), 32'(e.lv));
                    chk("dato_lectura", 32'(dato_lectura), 32'(e.dato));
                end
            end
        end
    end

    initial begin
        #2;
        chk("rst_ad_out", 32'(ad_out), 32'h00);
        chk("rst_ad_oe", 32'(ad_oe), 32'd0);
        chk("rst_dato", 32'(dato_lectura), 32'h00);
        chk("rst_pulses", {29'd0, listo, error, lectura_valida}, 32'd0);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        @(posedge reloj);
        @(posedge reloj);
        #1 resetM = 1'b0;

        run_frame(1, 0, 0, 32, 'h21, 'h5A, -1);
        run_frame(1, 1, 0, 32, 'h22, -1, 'hC3);
        run_frame(0, 1, 0, 32, -1, -1, -1);
        run_frame(1, 0, 1, 52, 'h33, 'h44, -1);
        run_frame(1, 1, 0, 32, -1, -1, -1);

        run_frame(1, 1, 0, 16, 'h40, -1, 'h99);
        push_evt(cyc + 2, 0, 1, 0, model_dato);
        run_frame(1, 0, 0, 32, 'h41, 'h77, -1);

        run_frame(1, 0, 0, 17, 'h55, 'hAA, -1);
        #2 resetM = 1'b1;
        #1;
        chk("arst_ad_oe", 32'(ad_oe), 32'd0);
        chk("arst_ad_out", 32'(ad_out), 32'h00);
        chk("arst_pulses", {29'd0, listo, error, lectura_valida}, 32'd0);
        chk("arst_ocupado", 32'(ocupado), 32'd0);
        chk("arst_dato", 32'(dato_lectura), 32'h00);
        bus_q.delete();
        evt_q.delete();
        model_dato = 8'h00;
        enable_cont_32 = 1'b0;
        A_D = 1'b1; WR = 1'b1; RD = 1'b1;
        @(posedge reloj);
        @(posedge reloj);
        #1 resetM = 1'b0;

        for (int i = 0; i < 20; i++)
            run_frame($urandom_range(0, 7) != 0, 1'($urandom), 0, 32, -1, -1, -1);

        repeat (6) @(posedge reloj);
        #1;
        enable_cont_32 = 1'b0;
        repeat (4) @(posedge reloj);
        #1;
        chk("pending_events", 32'(evt_q.size()), 32'd0);
        chk("pending_bus", 32'(bus_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_ad_rtc.md
# bus_ad_rtc

Drives and samples the RTC's multiplexed 8-bit address/data bus for one transaction per 32-cycle frame. It sits directly downstream of the RTC strobe generator and consumes that block's frame-start pulse and its registered strobes (A_D, WR, RD, LE). It places the latched address on the bus during the address phase, then either drives write data or releases the bus and captures read data on the closing edge of the read strobe. The transaction result and a done/error indication go back to the control path.

## Interface
- TIMEOUT, default 48: watchdog limit in cycles from frame start to the closing strobe edge.
- reloj  in  1  system clock, 100 MHz.
- resetM  in  1  asynchronous, active-high reset.
- enable_cont_32  in  1  frame-start pulse, one cycle high every 32 cycles.
- habilitar  in  1  sampled with enable_cont_32; 1 means run a transaction this frame.
- LE  in  1  1 = read, 0 = write; sampled with enable_cont_32.
- A_D  in  1  active-low address strobe.
- WR  in  1  active-low write strobe.
- RD  in  1  active-low read strobe.
- direccion  in  8  register address; sampled with enable_cont_32.
- dato_escritura  in  8  write data; sampled with enable_cont_32.
- ad_in  in  8  bus value from the pad buffer.
- ad_out  out  8  bus value to the pad buffer.
- ad_oe  out  1  pad output enable; 1 = drive.
- dato_lectura  out  8  last captured read byte; holds between reads.
- lectura_valida  out  1  one-cycle pulse when dato_lectura updates.
- listo  out  1  one-cycle pulse at the end of every completed transaction.
- error  out  1  one-cycle pulse on timeout or aborted transaction.
- ocupado  out  1  high in any state except IDLE.

## Operation
- Every input strobe (A_D, WR, RD) is registered once to form its *_q copy. ad_in is registered once to form ad_in_q. Edges are detected from the (*_q, current) pair.
- Latch condition: enable_cont_32=1 and habilitar=1. On a latch, direccion, dato_escritura and LE are stored in dir_l, dat_l and le_l, the watchdog is cleared, and the state goes to ADDR.
- IDLE: ad_oe=0. ad_out holds its last value. Waits for a latch.
- ADDR: ad_oe=1, ad_out=dir_l. On an A_D rising edge, go to WDATA if le_l=0, else to RDATA.
- WDATA: ad_oe=1, ad_out=dat_l. On a WR rising edge, pulse listo and go to IDLE.
- RDATA: ad_oe=0. On an RD rising edge, set dato_lectura<=ad_in_q, pulse lectura_valida and listo, and go to IDLE.
- Watchdog: a 6-bit counter that increments in every non-IDLE state. When it reaches TIMEOUT, pulse error, force ad_oe=0, and go to IDLE. dato_lectura is not changed.
- Latch condition while not in IDLE: pulse error, abort the current transaction, and start ADDR with the newly sampled operands in the same edge.
- enable_cont_32=1 with habilitar=0 while in IDLE: no action.
- Closing edge and timeout on the same cycle: the edge wins. The transaction completes normally and error stays 0.
- Changes to direccion, dato_escritura or LE after the latch have no effect until the next latch.

## Timing
- Reset values: ad_out=0x00, ad_oe=0, dato_lectura=0x00, lectura_valida=0, listo=0, error=0, ocupado=0, state IDLE, watchdog 0. Reset mid-transaction releases the bus immediately (asynchronously).
- T0 is the cycle in which enable_cont_32=1. Upstream strobe timing relative to T0:
  - A_D is low T2–T11.
  - First CS/WR-address window is T3–T9.
  - Data window is T21–T27: RD low for a read, WR low for a write.
- State and bus timing:
  - ADDR, ad_oe=1 and ocupado=1 from T1.
  - A_D rise is seen at T12, so WDATA or RDATA starts at T13. ad_oe stays 1 from T1 through T28 for a write, and drops to 0 at T13 for a read.
  - Closing edge is seen at T28. For a write, dat_l is still driven in T28, across the WR rising edge. For a read, the captured byte is ad_in as sampled at the end of T27.
  - listo and lectura_valida pulse in T29. ocupado=0 and the state is IDLE in T29.
- Latency from frame start to listo: 29 cycles. Throughput: one transaction per frame.
- All outputs are registered. ad_out and ad_oe change only on reloj edges, or asynchronously on reset.

## Test plan
- Write: habilitar=1, LE=0, direccion=0x21, dato_escritura=0x5A, nominal strobes → ad_out=0x21 over T1–T12 and 0x5A over T13–T28, ad_oe=1 over T1–T28, listo in T29, lectura_valida=0.
- Read: LE=1, direccion=0x22, ad_in=0xC3 during T21–T27 → ad_oe=0 from T13, dato_lectura=0xC3 and lectura_valida=listo=1 in T29; a following frame with habilitar=0 keeps 0xC3 and ocupado=0.
- Timeout: latch, then hold A_D low permanently → error pulses after exactly 48 cycles, ad_oe=0, state IDLE, dato_lectura unchanged.
- Abort: second enable_cont_32 pulse with habilitar=1 while in RDATA → error pulse, new direccion driven from the next cycle, and the old read is never reported.
- Reset mid-WDATA: assert resetM asynchronously between clock edges → ad_oe=0 and ad_out=0x00 before the next edge, all pulses 0.
- Operand isolation: change direccion and dato_escritura every cycle after T0 → the bus carries only the values sampled at T0.
